io_flag_controller: RTL

- Sequences the Basic Computer's 8-bit input register (INPR) and output register (OUTR).
- Owns the FGI/FGO handshake flags, the IEN interrupt-enable flip-flop and the printer-side output handshake.
- Sits between the control unit (register-reference I/O instruction strobes: INP, OUT, SKI, SKO, ION, IOF) and the external keyboard/printer.
- Includes an ack-timeout counter so a dead printer cannot hang FGO low.

---
 rtl/io_pkg.sv | 14 +
 rtl/io_out_fsm.sv | 72 +++++++
 rtl/io_flag_controller.sv | 104 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the Basic Computer I/O flag controller.
package io_pkg;

  localparam int BYTE_W = 8;

  // FGO powers up set: the printer is idle, so the CPU may issue OUT at once.
  localparam logic FGO_RST = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } out_state_t;

endpackage

// File: rtl/io_out_fsm.sv
// Printer-side output sequencer: IDLE/SEND state, ack-timeout counter and
// timeout pulse. The parent decides when a start is legal.
module io_out_fsm
  import io_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic prn_ack,
  output logic prn_valid,
  output logic done,
  output logic timeout
);

  localparam bit              TO_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] LAST  = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  out_state_t      state, state_n;
  logic [TO_W-1:0] cnt, cnt_n;
  logic            timeout_n;

  assign prn_valid = (state == SEND);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path
    // through the case statement can infer a latch.
    state_n   = state;
    cnt_n     = cnt;
    timeout_n = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND;
          cnt_n   = '0;
        end
      end
      SEND: begin
        // An ack arriving on the expiry cycle still counts as a delivery.
        if (prn_ack) begin
          state_n = IDLE;
          done    = 1'b1;
        end else if (TO_EN && (cnt == LAST)) begin
          state_n   = IDLE;
          done      = 1'b1;
          timeout_n = 1'b1;
        end else if (TO_EN) begin
          cnt_n = cnt + TO_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      timeout <= timeout_n;
    end
  end

endmodule

// File: rtl/io_flag_controller.sv
// Basic Computer I/O controller: INPR/OUTR, FGI/FGO/IEN flags, command
// decode and the printer handshake via io_out_fsm.
module io_flag_controller
  import io_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] kbd_data,
  input  logic              kbd_valid,
  output logic              kbd_ready,
  output logic [BYTE_W-1:0] prn_data,
  output logic              prn_valid,
  input  logic              prn_ack,
  input  logic [BYTE_W-1:0] ac_low,
  input  logic              cmd_inp,
  input  logic              cmd_out,
  input  logic              cmd_ski,
  input  logic              cmd_sko,
  input  logic              cmd_ion,
  input  logic              cmd_iof,
  input  logic              cmd_intack,
  output logic [BYTE_W-1:0] inpr,
  output logic              fgi,
  output logic              fgo,
  output logic              ien,
  output logic              skip,
  output logic              intr_req,
  output logic              io_err,
  output logic              timeout
);

  logic [5:0]        cmds;
  logic              multi, legal;
  logic              kbd_load, out_start, out_busy_err, out_done;
  logic [BYTE_W-1:0] outr;

  // More than one strobe set: x & (x-1) is nonzero iff two or more bits are high.
  assign cmds  = {cmd_inp, cmd_out, cmd_ski, cmd_sko, cmd_ion, cmd_iof};
  assign multi = |(cmds & (cmds - 6'd1));
  assign legal = ~multi;

  assign kbd_ready    = ~fgi;
  assign kbd_load     = kbd_valid & ~fgi;
  assign out_start    = legal & cmd_out & ~prn_valid;
  assign out_busy_err = legal & cmd_out & prn_valid;

  assign prn_data = outr;
  assign skip     = (cmd_ski & fgi) | (cmd_sko & fgo);
  assign intr_req = ien & (fgi | fgo);

  io_out_fsm #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_out_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (out_start),
    .prn_ack   (prn_ack),
    .prn_valid (prn_valid),
    .done      (out_done),
    .timeout   (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fgi    <= 1'b0;
      fgo    <= FGO_RST;
      ien    <= 1'b0;
      inpr   <= '0;
      outr   <= '0;
      io_err <= 1'b0;
    end else begin
      io_err <= multi | out_busy_err;

      // A keyboard byte landing in the same cycle as INP wins: FGI ends set.
      if (kbd_load) begin
        inpr <= kbd_data;
        fgi  <= 1'b1;
      end else if (legal && cmd_inp) begin
        fgi <= 1'b0;
      end

      // Start and done are mutually exclusive (IDLE vs SEND).
      if (out_start) begin
        outr <= ac_low;
        fgo  <= 1'b0;
      end else if (out_done) begin
        fgo <= 1'b1;
      end

      if (cmd_intack) begin
        ien <= 1'b0;
      end else if (legal && cmd_ion) begin
        ien <= 1'b1;
      end else if (legal && cmd_iof) begin
        ien <= 1'b0;
      end
    end
  end

endmodule
